// File: rtl/obstacle_pkg.sv
// Purpose : shared constants, state encoding and gap table for the obstacle column generator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package obstacle_pkg;

    localparam int                  OBS_LFSR_W     = 16;
    localparam logic [OBS_LFSR_W-1:0] OBS_SEED     = 16'hACE1;
    localparam logic [OBS_LFSR_W-1:0] OBS_TAPS     = 16'hB400;  // x^16+x^14+x^13+x^11, Galois form
    localparam int                  OBS_FIFO_DEPTH = 4;
    localparam int                  OBS_H_W        = 2;
    localparam int                  GAP_W          = 4;         // largest gap is 10 + 3 = 13
    localparam int                  PIPES_W        = 14;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Minimum run of open columns between pipes, indexed by the difficulty switch.
    function automatic logic [GAP_W-1:0] base_gap(input logic [1:0] difficulty);
        logic [GAP_W-1:0] gap;
        unique case (difficulty)
            2'b00:   gap = 4'd6;
            2'b01:   gap = 4'd4;
            2'b10:   gap = 4'd3;
            default: gap = 4'd10;
        endcase
        return gap;
    endfunction

endpackage

// File: rtl/obstacle_gen_if.sv
// Purpose : control/column bus between the game datapath (master) and the generator (slave).
// Latency : n/a (wires only).
// Backpressure: none; advance is a pop request, col_valid tells whether a column is present.
//   start/advance/difficulty : master -> slave
//   col_height/col_valid/underflow/pipes_out : slave -> master
interface obstacle_gen_if;
    import obstacle_pkg::*;

    logic               start;
    logic               advance;
    logic [1:0]         difficulty;
    logic [OBS_H_W-1:0] col_height;
    logic               col_valid;
    logic               underflow;
    logic [PIPES_W-1:0] pipes_out;

    modport master (
        output start, advance, difficulty,
        input  col_height, col_valid, underflow, pipes_out
    );

    modport slave (
        input  start, advance, difficulty,
        output col_height, col_valid, underflow, pipes_out
    );
endinterface

// File: rtl/obs_fifo.sv
// Purpose : small synchronous FIFO; head is the registered entry at the read pointer (0 when empty).
// Latency : push at edge N is visible at head/!empty after edge N.
// Backpressure: push dropped when full unless a pop happens in the same cycle; pop ignored when empty.
//   clk/resetn : clock, synchronous active-low reset;  clr : synchronous flush
//   push/push_dat, pop : write and read requests;  full/empty/head : status and head data
module obs_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A pop frees the slot the push needs, so full+pop still accepts the write.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/obstacle_gen.sv
// Purpose : LFSR-driven pipe-column source feeding a prefetch FIFO for the scrolling datapath.
// Latency : generated column visible one cycle after generation; FIFO full FIFO_DEPTH cycles after start.
// Backpressure: generation stalls (LFSR and gap hold) while the FIFO is full and not popped.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : start/advance/difficulty in; col_height/col_valid/underflow/pipes_out out
module obstacle_gen import obstacle_pkg::*; #(
    parameter int                LFSR_W     = OBS_LFSR_W,
    parameter logic [LFSR_W-1:0] SEED       = OBS_SEED,
    parameter logic [LFSR_W-1:0] TAPS       = OBS_TAPS,
    parameter int                FIFO_DEPTH = OBS_FIFO_DEPTH,
    parameter int                H_W        = OBS_H_W
) (
    input  logic           clk,
    input  logic           resetn,
    obstacle_gen_if.slave  bus
);
    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               underflow_q, underflow_d;
    logic [PIPES_W-1:0] pipes_q, pipes_d;

    logic               fifo_full, fifo_empty;
    logic [H_W-1:0]     head;
    logic [H_W-1:0]     push_dat;
    logic               gen, pop;

    obs_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (H_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (bus.start),
        .push     (gen),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        gap_d       = gap_q;
        underflow_d = underflow_q;
        pipes_d     = pipes_q;
        push_dat    = '0;
        pop         = bus.advance && !fifo_empty;
        gen         = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                gen = !fifo_full || pop;
                if (fifo_full) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                gen = !fifo_full || pop;
            end
        endcase

        if (gen) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
            if (gap_q != '0) begin
                gap_d = gap_q - 1'b1;
            end else begin
                // Height 0 is reserved for open columns, so a zero draw becomes the lowest pipe.
                push_dat = (lfsr_q[1:0] == 2'b00) ? H_W'(1) : H_W'(lfsr_q[1:0]);
                // Difficulty is only looked at here, so a switch never cuts a gap short.
                gap_d    = base_gap(bus.difficulty) + GAP_W'(lfsr_q[3:2]);
            end
        end

        if (bus.advance && fifo_empty) begin
            underflow_d = 1'b1;
        end
        if (pop && (head != '0) && (pipes_q != '1)) begin
            pipes_d = pipes_q + 1'b1;
        end

        // start overrides everything, including any advance in the same cycle.
        if (bus.start) begin
            state_d     = ST_FILL;
            lfsr_d      = SEED;
            gap_d       = base_gap(bus.difficulty);
            underflow_d = 1'b0;
            pipes_d     = '0;
            gen         = 1'b0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_FILL;
            lfsr_q      <= SEED;
            gap_q       <= base_gap(bus.difficulty);
            underflow_q <= 1'b0;
            pipes_q     <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            gap_q       <= gap_d;
            underflow_q <= underflow_d;
            pipes_q     <= pipes_d;
        end
    end

    assign bus.col_height = head;
    assign bus.col_valid  = !fifo_empty;
    assign bus.underflow  = underflow_q;
    assign bus.pipes_out  = pipes_q;
endmodule

// File: tb/tb_obstacle_gen.sv
// Purpose : directed sequence with randomized spacing against a column-sequence reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_obstacle_gen;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    obstacle_gen_if ifc();
    obstacle_gen dut (.clk(clk), .resetn(resetn), .bus(ifc));

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int obs_q[$];

    function automatic int ref_gap(input logic [1:0] d);
        case (d)
            2'b00:   return 6;
            2'b01:   return 4;
            2'b10:   return 3;
            default: return 10;
        endcase
    endfunction

    // Expected column stream: difficulty d0 for columns before index sw, d1 from then on.
    task automatic build_model(input int n, input int sw, input logic [1:0] d0, input logic [1:0] d1);
        int unsigned l;
        int g;
        logic [1:0] d;
        exp_q.delete();
        l = 32'hACE1;
        g = ref_gap(d0);
        for (int i = 0; i < n; i++) begin
            d = (i < sw) ? d0 : d1;
            if (g > 0) begin
                exp_q.push_back(0);
                g = g - 1;
            end else begin
                exp_q.push_back(((l % 4) == 0) ? 1 : int'(l % 4));
                g = ref_gap(d) + int'((l / 4) % 4);
            end
            l = ((l % 2) == 1) ? ((l / 2) ^ 32'hB400) : (l / 2);
        end
    endtask

    function automatic int count_pipes(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (exp_q[i] != 0) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the head, pop it, then idle for the given number of cycles.
    task automatic pop_chk(input string tag, input int idx, input int idle);
        chk($sformatf("%s_vld%0d", tag, idx), 32'(ifc.col_valid), 1);
        chk($sformatf("%s_h%0d", tag, idx), 32'(ifc.col_height), exp_q[idx]);
        obs_q.push_back(int'(ifc.col_height));
        ifc.advance = 1'b1;
        @(negedge clk);
        ifc.advance = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, run;
        bit first;
        resetn         = 1'b0;
        ifc.start      = 1'b0;
        ifc.advance    = 1'b0;
        ifc.difficulty = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_vld", 32'(ifc.col_valid), 0);
        chk("rst_h", 32'(ifc.col_height), 0);
        chk("rst_uf", 32'(ifc.underflow), 0);
        chk("rst_pipes", 32'(ifc.pipes_out), 0);

        // Fill after reset, then hold while full.
        build_model(1200, 1200, 2'b00, 2'b00);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("fill_vld", 32'(ifc.col_valid), 1);
        chk("fill_cnt", 32'(dut.u_fifo.count_q), 4);
        repeat (3) @(negedge clk);
        chk("hold_cnt", 32'(dut.u_fifo.count_q), 4);

        // 1000 pops, 3 cycles apart.
        for (int i = 0; i < 1000; i++) pop_chk("t2", i, 2);
        chk("t2_uf", 32'(ifc.underflow), 0);
        chk("t2_pipes", 32'(ifc.pipes_out), count_pipes(1000));

        // Sustained pop every cycle after a restart.
        pulse_start();
        repeat (4) @(negedge clk);
        ifc.advance = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("t3_vld%0d", i), 32'(ifc.col_valid), 1);
            chk($sformatf("t3_h%0d", i), 32'(ifc.col_height), exp_q[i]);
            chk($sformatf("t3_cnt%0d", i), 32'(dut.u_fifo.count_q), 4);
            @(negedge clk);
        end
        ifc.advance = 1'b0;
        chk("t3_uf", 32'(ifc.underflow), 0);
        chk("t3_pipes", 32'(ifc.pipes_out), count_pipes(60));

        // advance in the first cycle after start, with the FIFO still empty.
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start   = 1'b0;
        ifc.advance = 1'b1;
        @(negedge clk);
        ifc.advance = 1'b0;
        chk("t4_uf", 32'(ifc.underflow), 1);
        chk("t4_h", 32'(ifc.col_height), 0);
        chk("t4_pipes", 32'(ifc.pipes_out), 0);
        repeat (10) @(negedge clk);
        chk("t4_uf_sticky", 32'(ifc.underflow), 1);

        // Random number of pops, then a one-cycle reset mid-run.
        k = $urandom_range(5, 20);
        for (int i = 0; i < k; i++) pop_chk("t5a", i, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_rst_vld", 32'(ifc.col_valid), 0);
        chk("t5_rst_h", 32'(ifc.col_height), 0);
        chk("t5_rst_uf", 32'(ifc.underflow), 0);
        chk("t5_rst_pipes", 32'(ifc.pipes_out), 0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 200; i++) pop_chk("t5", i, 2);
        chk("t5_uf", 32'(ifc.underflow), 0);
        chk("t5_pipes", 32'(ifc.pipes_out), count_pipes(200));

        // Difficulty 00 -> 10 while the first gap is in progress and the FIFO is full (4 generated).
        ifc.difficulty = 2'b00;
        pulse_start();
        repeat (4) @(negedge clk);
        ifc.difficulty = 2'b10;
        build_model(400, 4, 2'b00, 2'b10);
        obs_q.delete();
        for (int i = 0; i < 300; i++) pop_chk("t6", i, $urandom_range(0, 3));
        run   = 0;
        first = 1'b1;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 0) begin
                run++;
            end else begin
                if (first) chk("t6_first_gap", 32'(run), 6);
                else       chk($sformatf("t6_gap_rng%0d", i), 32'(run >= 3 && run <= 6), 1);
                run   = 0;
                first = 1'b0;
            end
        end
        chk("t6_uf", 32'(ifc.underflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
